// File: rtl/vec_alu_pkg.sv
// Shared types and helpers for the multi-cycle vector ALU.
package vec_alu_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_MUL  = 5'd5,
    OP_SADD = 5'd6,
    OP_MAXU = 5'd7
  } vec_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vec_state_e;

  // Number of clock beats needed to sweep the whole vector.
  function automatic int calc_beats(input int vlen, input int elem_w, input int lanes);
    return vlen / (elem_w * lanes);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-element ALU; one copy per lane.
module vec_lane_alu #(
  parameter int ELEM_W = 8,
  parameter int OP_W   = vec_alu_pkg::OP_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] y
);
  import vec_alu_pkg::*;

  logic [ELEM_W:0]     sum_ext;
  logic [2*ELEM_W-1:0] prod;

  // Element result; all arithmetic unsigned, unknown opcodes give zero.
  always_comb begin
    sum_ext = {1'b0, a} + {1'b0, b};
    prod    = {{ELEM_W{1'b0}}, a} * {{ELEM_W{1'b0}}, b};
    y       = '0;
    case (op)
      OP_ADD:  y = sum_ext[ELEM_W-1:0];
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_MUL:  y = prod[ELEM_W-1:0];
      OP_SADD: y = sum_ext[ELEM_W] ? {ELEM_W{1'b1}} : sum_ext[ELEM_W-1:0];
      OP_MAXU: y = (a > b) ? a : b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_alu_multicycle.sv
// Multi-cycle vector ALU: processes LANES elements per beat, BEATS beats per op.
module vector_alu_multicycle #(
  parameter int VLEN   = 128,
  parameter int ELEM_W = 8,
  parameter int LANES  = 4,
  parameter int OP_W   = vec_alu_pkg::OP_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [OP_W-1:0] op,
  input  logic [VLEN-1:0] src_a,
  input  logic [VLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [VLEN-1:0] result
);
  import vec_alu_pkg::*;

  localparam int BEATS  = calc_beats(VLEN, ELEM_W, LANES);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if (VLEN % (ELEM_W * LANES) != 0) begin : g_bad_config
    $error("VLEN must be a multiple of ELEM_W*LANES");
  end

  vec_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q;
  logic [OP_W-1:0]   op_q;
  logic [VLEN-1:0]   a_q, b_q;
  logic [VLEN-1:0]   work_q, work_d;
  logic [VLEN-1:0]   result_q;
  logic              accept;
  logic              last_beat;

  logic [ELEM_W-1:0] lane_a [LANES];
  logic [ELEM_W-1:0] lane_b [LANES];
  logic [ELEM_W-1:0] lane_y [LANES];

  assign accept    = ((state_q == IDLE) || (state_q == DONE)) && start && !flush;
  assign last_beat = (beat_q == LAST_BEAT);
  assign result    = result_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_a[l] = a_q[(int'(beat_q) * LANES + l) * ELEM_W +: ELEM_W];
    assign lane_b[l] = b_q[(int'(beat_q) * LANES + l) * ELEM_W +: ELEM_W];

    vec_lane_alu #(
      .ELEM_W(ELEM_W),
      .OP_W  (OP_W)
    ) u_lane (
      .op(op_q),
      .a (lane_a[l]),
      .b (lane_b[l]),
      .y (lane_y[l])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = start ? RUN : IDLE;
        RUN:     state_d = last_beat ? DONE : RUN;
        DONE:    state_d = start ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Merge this beat's lane results into the work vector.
  always_comb begin
    work_d = work_q;
    for (int l = 0; l < LANES; l++) begin
      work_d[(int'(beat_q) * LANES + l) * ELEM_W +: ELEM_W] = lane_y[l];
    end
  end

  // Operand capture on an accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= src_a;
      b_q  <= src_b;
    end
  end

  // Beat counter and work register; the counter holds at the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
      work_q <= '0;
    end else if (flush || accept) begin
      beat_q <= '0;
      work_q <= '0;
    end else if (state_q == RUN) begin
      work_q <= work_d;
      if (!last_beat) beat_q <= beat_q + 1'b1;
    end
  end

  // Publish the finished vector on the final beat unless flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else if (!flush && (state_q == RUN) && last_beat) begin
      result_q <= work_d;
    end
  end

endmodule

// File: tb/tb_vector_alu_multicycle.sv
// Scoreboard bench for vector_alu_multicycle (BEATS=4 and BEATS=1 instances).
module tb_vector_alu_multicycle;

  logic         clk;
  logic         reset;
  logic         start;
  logic         start2;
  logic         flush;
  logic [4:0]   op;
  logic [127:0] src_a;
  logic [127:0] src_b;
  logic         busy, done;
  logic [127:0] result;
  logic         busy2, done2;
  logic [127:0] result2;

  int           compare_count;
  int           mismatch_count;
  logic [127:0] exp_q [$];
  string        tag_q [$];
  logic [127:0] last_exp;
  logic [127:0] mon_exp;
  string        mon_tag;

  vector_alu_multicycle #(.VLEN(128), .ELEM_W(8), .LANES(4), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  vector_alu_multicycle #(.VLEN(128), .ELEM_W(8), .LANES(16), .OP_W(5)) dut_wide (
    .clk(clk), .reset(reset), .start(start2), .flush(flush), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy2), .done(done2), .result(result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [127:0] vec_model(input logic [4:0] o, input logic [127:0] a, input logic [127:0] b);
    logic [127:0] r;
    logic [7:0]   x, y, e;
    logic [8:0]   s;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      x = a[i*8 +: 8];
      y = b[i*8 +: 8];
      s = {1'b0, x} + {1'b0, y};
      case (o)
        5'd0: e = x + y;
        5'd1: e = x - y;
        5'd2: e = x & y;
        5'd3: e = x | y;
        5'd4: e = x ^ y;
        5'd5: e = x * y;
        5'd6: e = s[8] ? 8'hFF : s[7:0];
        5'd7: e = (x > y) ? x : y;
        default: e = 8'h00;
      endcase
      r[i*8 +: 8] = e;
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one operation for a single accepting edge; optionally score it.
  task automatic apply_stimulus(input logic [4:0] op_v, input logic [127:0] a_v, input logic [127:0] b_v,
                                input string tag, input bit expect_done);
    @(negedge clk);
    start = 1'b1;
    op    = op_v;
    src_a = a_v;
    src_b = b_v;
    if (expect_done) begin
      exp_q.push_back(vec_model(op_v, a_v, b_v));
      tag_q.push_back(tag);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done, checking latency and busy length; returns at the done negedge.
  task automatic wait_done(input string tag, input int exp_lat);
    int busy_n;
    int lat;
    bit seen;
    busy_n = 0;
    lat    = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else if (busy) begin
        busy_n++;
      end
    end
    if (!seen) begin
      check_output({tag, "_timeout"}, 128'(done), 128'd1);
    end else begin
      check_output({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      check_output({tag, "_busy_len"}, 128'(busy_n), 128'(exp_lat));
      check_output({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    end
  endtask

  // Scoreboard: every done pulse pops and compares one expected vector.
  always @(negedge clk) begin
    if (reset && done) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_done", 128'(done), 128'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check_output({mon_tag, "_result"}, result, mon_exp);
        last_exp = mon_exp;
      end
    end
  end

  logic [127:0] a_v, b_v, prev;
  logic [4:0]   table_ops [6];
  int           gap;
  int           lat2;
  bit           seen;

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    last_exp = '0;
    start  = 1'b0;
    start2 = 1'b0;
    flush  = 1'b0;
    op     = '0;
    src_a  = '0;
    src_b  = '0;
    reset  = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_busy", 128'(busy), 128'd0);
    check_output("reset_done", 128'(done), 128'd0);
    check_output("reset_result", result, 128'd0);
    check_output("reset_result_wide", result2, 128'd0);
    reset = 1'b1;

    // Basic opcodes from the plan.
    apply_stimulus(5'd0, {16{8'hFF}}, {16{8'h01}}, "add_wrap", 1'b1);
    wait_done("add_wrap", 4);
    apply_stimulus(5'd6, {16{8'hF0}}, {16{8'h20}}, "sadd_sat", 1'b1);
    wait_done("sadd_sat", 4);
    apply_stimulus(5'd5, {16{8'h03}}, {16{8'h05}}, "mul_low", 1'b1);
    wait_done("mul_low", 4);

    // Distinct per-element operands exercise the beat-to-lane mapping.
    for (int i = 0; i < 16; i++) begin
      a_v[i*8 +: 8] = 8'(i);
      b_v[i*8 +: 8] = 8'(2 * i);
    end
    apply_stimulus(5'd1, a_v, b_v, "sub_map", 1'b1);
    wait_done("sub_map", 4);

    // Remaining opcodes plus unknown ones, random operands.
    table_ops = '{5'd2, 5'd3, 5'd4, 5'd7, 5'd9, 5'd31};
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(table_ops[k], rand_vec(), rand_vec(), $sformatf("op%0d", table_ops[k]), 1'b1);
      wait_done($sformatf("op%0d", table_ops[k]), 4);
    end

    // Flush at beat 2: no done, result untouched, then a clean restart.
    prev = last_exp;
    apply_stimulus(5'd0, rand_vec(), rand_vec(), "flushed", 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check_output("flush_busy", 128'(busy), 128'd0);
    check_output("flush_done", 128'(done), 128'd0);
    check_output("flush_hold", result, prev);
    repeat (6) @(negedge clk);
    check_output("flush_hold_later", result, prev);
    apply_stimulus(5'd7, rand_vec(), rand_vec(), "after_flush", 1'b1);
    wait_done("after_flush", 4);

    // Back-to-back start in DONE; a start pulse during RUN must be ignored.
    apply_stimulus(5'd4, rand_vec(), rand_vec(), "b2b_first", 1'b1);
    wait_done("b2b_first", 4);
    a_v   = rand_vec() | 128'h1;
    b_v   = rand_vec();
    start = 1'b1;
    op    = 5'd3;
    src_a = a_v;
    src_b = b_v;
    exp_q.push_back(vec_model(5'd3, a_v, b_v));
    tag_q.push_back("b2b_second");
    gap  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      gap++;
      if (done) seen = 1'b1;
      if (gap == 1) begin
        op    = 5'd4;
        src_a = ~a_v;
      end else if (gap == 2) begin
        start = 1'b0;
      end
    end
    check_output("b2b_gap", 128'(gap), 128'd5);
    repeat (6) @(negedge clk);

    // Asynchronous reset during beat 1 clears everything at once.
    apply_stimulus(5'd0, rand_vec(), rand_vec(), "reset_mid", 1'b0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_output("rst_mid_busy", 128'(busy), 128'd0);
    check_output("rst_mid_done", 128'(done), 128'd0);
    check_output("rst_mid_result", result, 128'd0);
    last_exp = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_output("rst_mid_idle", 128'(busy), 128'd0);

    // Single-beat configuration: done one edge after acceptance.
    for (int k = 0; k < 2; k++) begin
      a_v = (k == 0) ? {16{8'hFF}} : rand_vec();
      b_v = (k == 0) ? {16{8'h01}} : rand_vec();
      @(negedge clk);
      start2 = 1'b1;
      op     = 5'd0;
      src_a  = a_v;
      src_b  = b_v;
      @(posedge clk);
      #1 start2 = 1'b0;
      lat2 = 0;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (done2) begin
          seen = 1'b1;
          lat2 = i;
        end
      end
      if (!seen) begin
        check_output("wide_timeout", 128'(done2), 128'd1);
      end else begin
        check_output("wide_latency", 128'(lat2), 128'd1);
        check_output("wide_result", result2, vec_model(5'd0, a_v, b_v));
      end
    end

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/vector_alu_multicycle.md
# vector_alu_multicycle

Parametrised, multi-cycle successor to the single-shot vector ALU in the execute stage. It splits a VLEN-bit vector operation into BEATS = VLEN/(ELEM_W*LANES) beats and processes LANES elements per clock, trading latency for area. A start/busy/done handshake lets the hazard unit stall the front of the pipeline while it runs. A flush input aborts an operation in flight on a taken branch.

## Interface
- VLEN, 128, vector width in bits
- ELEM_W, 8, element width in bits
- LANES, 4, elements processed per cycle; VLEN % (ELEM_W*LANES) must be 0 (elaboration-time assertion)
- OP_W, 5, opcode width, matching the existing aluVectorOp field
- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled only in IDLE or DONE
- flush  input  1  synchronous abort
- op  input  OP_W  operation code, latched on an accepted start
- src_a  input  VLEN  operand A, latched on an accepted start
- src_b  input  VLEN  operand B, latched on an accepted start
- busy  output  1  high while state == RUN; drives the stall/nop path of the hazard unit
- done  output  1  one-cycle pulse; result valid
- result  output  VLEN  last completed result; held until the next completion

## Operation
- Element i occupies bits [i*ELEM_W +: ELEM_W]. Beat k covers elements k*LANES .. k*LANES+LANES-1.
- Opcodes (all unsigned, truncated to ELEM_W):
  - 0 ADD, wraps
  - 1 SUB, wraps
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MUL, low ELEM_W bits of the product
  - 6 SADD, saturates at 2^ELEM_W-1
  - 7 MAXU
  - Any other opcode yields zero elements.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: start=1 latches op/src_a/src_b, clears beat counter and work register, goes to RUN.
  - RUN: each cycle writes LANES results into the work register at the current beat and increments the beat counter. After beat BEATS-1 the work register is copied to result, done is set, and the FSM goes to DONE.
  - DONE: done=1 for this single cycle. start=1 here is accepted exactly as in IDLE (back-to-back, goes to RUN); otherwise go to IDLE.
  - start while in RUN is ignored; the upstream is already stalled by busy.
- flush has priority over start and over beat progress in every state.
  - Next state is IDLE and done is forced to 0.
  - result is not updated and the work register is discarded.
  - flush together with start in IDLE/DONE: start is dropped.
- Beat counter width is clog2(BEATS) with a minimum of 1 bit. It never wraps past BEATS-1.

## Timing
- Reset values: state IDLE, beat 0, busy 0, done 0, result 0, latched operands 0.
- start accepted at edge t:
  - busy is high for cycles t..t+BEATS-1, ending at edge t+BEATS.
  - done is high in the cycle between edges t+BEATS and t+BEATS+1.
  - result changes at edge t+BEATS.
- Throughput with back-to-back starts: one operation every BEATS+1 cycles.
- BEATS=1 (LANES = VLEN/ELEM_W): a single RUN cycle; done follows one edge later.
- Reset asserted mid-operation: all state returns to reset values immediately, with no done pulse. Deassertion is synchronised externally.
- busy and done are registered outputs with no combinational path from the inputs.

## Structure
- Package vec_alu_pkg holds:
  - the opcode enum (ADD..MAXU) and OP_W
  - the state enum (IDLE, RUN, DONE)
  - a function computing BEATS from VLEN, ELEM_W and LANES
- Sub-module vec_lane_alu: combinational single-element ALU (op, a, b -> y, all ELEM_W wide), generated LANES times. The operand slices are selected by the beat counter.

## Test plan
All scenarios use VLEN=128, ELEM_W=8, LANES=4 (BEATS=4) unless noted.
- ADD, all elements A=0xFF, B=0x01 -> result all 0x00 (wrap); busy high 4 cycles; done at start+4.
- SADD A=0xF0, B=0x20 in every element; MUL A=0x03, B=0x05 -> 0xFF in every element; 0x0F in every element.
- Per-element distinct operands A[i]=i, B[i]=2i with SUB -> element i = 0xFF & (-i). Checks beat-to-lane mapping across all 16 elements.
- flush asserted at beat 2 of an ADD -> IDLE next cycle, no done, result keeps its previous value. A following start completes normally.
- start asserted during the DONE cycle with a new op -> second done exactly 5 cycles after the first. start pulsed during RUN -> ignored.
- reset pulled low at beat 1 -> busy, done and result are 0 immediately. Repeat the ADD case with LANES=16 (BEATS=1) -> done at start+1.
